arf_ctrl_seq: RTL
=================

Name: arf_ctrl_seq

Overview:
- Control-side sequencer that drives the address register file (ARF) control port: FunSel, RSel, OutASel and OutBSel, plus the ARF input-mux select.
- Turns single-cycle requests (init, jump, fetch, push, pop) into multi-cycle ARF and memory strobe sequences.
- Sits between the instruction decoder/control unit and the ARF/memory; it is the initiator on the interface for which the ARF is the responder.

Parameters:
- FETCH_BYTES, 2, instruction bytes fetched per FETCH request. Legal values are 1 or 2.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- init_req  in  1  clear PC, AR, SP and PCPast.
- jump_req  in  1  load PC from jump_addr.
- jump_addr  in  8  jump target, routed to the ARF I input when arf_in_sel=0.
- fetch_req  in  1  fetch an instruction at PC.
- push_req  in  1  stack write at SP, post-decrement.
- pop_req  in  1  stack read, pre-increment SP.
- arf_funsel  out  2  ARF FunSel: 00 clear, 01 load, 10 inc, 11 dec.
- arf_rsel  out  4  ARF RSel: bit3 PC, bit2 AR, bit1 SP, bit0 PCPast.
- arf_outasel  out  2  ARF OutASel: 00 AR, 01 SP, 10 PCPast, 11 PC. OutA is the memory address.
- arf_outbsel  out  2  ARF OutBSel, same encoding.
- arf_in_sel  out  1  ARF I source: 0 jump_addr, 1 ARF OutB feedback.
- mem_rd  out  1  memory read strobe; address is ARF OutA.
- mem_wr  out  1  memory write strobe; address is ARF OutA.
- ir_lsb_ld  out  1  IR low-byte load strobe.
- ir_msb_ld  out  1  IR high-byte load strobe.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse in the last state of an operation.

Behaviour:
- Moore FSM. All outputs are decoded from state only.
- ARF timing used by this block: ARF OutA/OutB register the pre-update register value at the same edge that applies FunSel/RSel.
- Reset, asynchronous and taking effect mid-operation: state=IDLE. Outputs take their IDLE values immediately:
  - funsel=00, rsel=0000, outasel=11, outbsel=01, in_sel=0.
  - All strobes, busy and done = 0.
  - rsel=0000 means no ARF register changes.
- IDLE: requests are sampled here only. Priority: init > jump > fetch > push > pop. Requests arriving while busy=1 are ignored.
- INIT (1 cycle): rsel=1111, funsel=00, done=1 -> IDLE.
- JUMP (1 cycle): rsel=1000, funsel=01, in_sel=0, done=1 -> IDLE.
- FETCH, FETCH_BYTES=2:
  - F0: outasel=11, rsel=1000, funsel=10. OutA captures old PC; PC increments.
  - F1: mem_rd=1, ir_lsb_ld=1, outasel=11, rsel=1000, funsel=10.
  - F2: mem_rd=1, ir_msb_ld=1, done=1 -> IDLE.
  - Total 3 cycles; PC advances by 2.
- FETCH, FETCH_BYTES=1: F0, then F1 with done=1 and no second increment. PC advances by 1.
- PUSH:
  - S0: outasel=01, rsel=0010, funsel=11. OutA captures old SP.
  - S1: mem_wr=1, done=1 -> IDLE.
- POP:
  - Q0: rsel=0010, funsel=10.
  - Q1: outasel=01. OutA captures the incremented SP.
  - Q2: mem_rd=1, done=1 -> IDLE.
- Wrap-around is the ARF's modulo-256 arithmetic; this block performs no checks. PC=FF fetch reads FF then 00. SP=00 push leaves SP=FF.
- done and busy are both high in final states. busy falls the cycle after done. A new request can be accepted the cycle busy=0.

Optional Feature:
- Macro: ARF_SEQ_PCPAST_EN.
- Defined: JUMP becomes 3 cycles, which saves the return address in PCPast.
  - J0: outbsel=11; OutB captures PC.
  - J1: rsel=0001, funsel=01, in_sel=1; PCPast loads the old PC.
  - J2: rsel=1000, funsel=01, in_sel=0, done=1.
- Undefined: JUMP is a single cycle, PCPast is never written by jumps, and in_sel is held at 0.

Test Plan:
- rst_n low in FETCH F1 -> all strobes 0 and busy=0 asynchronously. After release, IDLE with outasel=11.
- init_req, then fetch_req with memory [00]=3C, [01]=A5 -> IR=A53C, PC=02, busy high 3 cycles, done on the 3rd.
- jump_req with jump_addr=FF, then fetch -> IR bytes read from FF and 00, PC=01.
- init (SP=00), push -> write at address 00, SP=FF. Then pop -> SP=00, read at address 00.
- fetch_req, push_req and pop_req asserted together in IDLE -> fetch only. push/pop asserted during busy are ignored and SP is unchanged.
- With ARF_SEQ_PCPAST_EN and PC=12, jump to 40 -> PCPast=12, PC=40, done in cycle 3. Without the macro, PCPast is unchanged.

Source files
------------

// File: rtl/arf_ctrl_seq.sv
// arf_ctrl_seq: Moore sequencer driving the address register file control
// port (FunSel/RSel/OutASel/OutBSel), the ARF input mux and memory/IR strobes.
// Single-cycle requests sampled in IDLE become multi-cycle ARF sequences.
// Optional build macro: ARF_SEQ_PCPAST_EN (3-cycle JUMP saving PC in PCPast).
module arf_ctrl_seq #(
  parameter int FETCH_BYTES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       init_req,
  input  logic       jump_req,
  input  logic [7:0] jump_addr,
  input  logic       fetch_req,
  input  logic       push_req,
  input  logic       pop_req,
  output logic [1:0] arf_funsel,
  output logic [3:0] arf_rsel,
  output logic [1:0] arf_outasel,
  output logic [1:0] arf_outbsel,
  output logic       arf_in_sel,
  output logic       mem_rd,
  output logic       mem_wr,
  output logic       ir_lsb_ld,
  output logic       ir_msb_ld,
  output logic       busy,
  output logic       done
);

  // Anything other than 1 is treated as the two-byte fetch.
  localparam bit TWO_BYTE = (FETCH_BYTES != 1);

  typedef enum logic [3:0] {
    IDLE, INIT, JUMP, J0, J1, F0, F1, F2, S0, S1, Q0, Q1, Q2
  } state_t;

  state_t state, state_next;

  // jump_addr is the I input only while in_sel=0; it is routed externally.
  logic unused_addr;
  assign unused_addr = ^jump_addr;

  // State register; reset returns to IDLE immediately, even mid-operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state: requests are only looked at in IDLE, highest priority wins.
  always_comb begin
    state_next = IDLE;
    case (state)
      IDLE: begin
        if (init_req)       state_next = INIT;
`ifdef ARF_SEQ_PCPAST_EN
        else if (jump_req)  state_next = J0;
`else
        else if (jump_req)  state_next = JUMP;
`endif
        else if (fetch_req) state_next = F0;
        else if (push_req)  state_next = S0;
        else if (pop_req)   state_next = Q0;
        else                state_next = IDLE;
      end
`ifdef ARF_SEQ_PCPAST_EN
      J0:      state_next = J1;
      J1:      state_next = JUMP;
`endif
      F0:      state_next = F1;
      F1:      state_next = TWO_BYTE ? F2 : IDLE;
      S0:      state_next = S1;
      Q0:      state_next = Q1;
      Q1:      state_next = Q2;
      default: state_next = IDLE;
    endcase
  end

  // Output decode from state only; defaults are the quiet IDLE values.
  always_comb begin
    arf_funsel  = 2'b00;
    arf_rsel    = 4'b0000;
    arf_outasel = 2'b11;
    arf_outbsel = 2'b01;
    arf_in_sel  = 1'b0;
    mem_rd      = 1'b0;
    mem_wr      = 1'b0;
    ir_lsb_ld   = 1'b0;
    ir_msb_ld   = 1'b0;
    busy        = (state != IDLE);
    done        = 1'b0;
    case (state)
      INIT: begin
        arf_rsel   = 4'b1111;
        arf_funsel = 2'b00;
        done       = 1'b1;
      end
`ifdef ARF_SEQ_PCPAST_EN
      J0: begin
        arf_outbsel = 2'b11;
      end
      J1: begin
        arf_rsel   = 4'b0001;
        arf_funsel = 2'b01;
        arf_in_sel = 1'b1;
      end
`endif
      JUMP: begin
        arf_rsel   = 4'b1000;
        arf_funsel = 2'b01;
        arf_in_sel = 1'b0;
        done       = 1'b1;
      end
      F0: begin
        arf_outasel = 2'b11;
        arf_rsel    = 4'b1000;
        arf_funsel  = 2'b10;
      end
      F1: begin
        mem_rd    = 1'b1;
        ir_lsb_ld = 1'b1;
        if (TWO_BYTE) begin
          arf_outasel = 2'b11;
          arf_rsel    = 4'b1000;
          arf_funsel  = 2'b10;
        end else begin
          done = 1'b1;
        end
      end
      F2: begin
        mem_rd    = 1'b1;
        ir_msb_ld = 1'b1;
        done      = 1'b1;
      end
      S0: begin
        arf_outasel = 2'b01;
        arf_rsel    = 4'b0010;
        arf_funsel  = 2'b11;
      end
      S1: begin
        mem_wr = 1'b1;
        done   = 1'b1;
      end
      Q0: begin
        arf_rsel   = 4'b0010;
        arf_funsel = 2'b10;
      end
      Q1: begin
        arf_outasel = 2'b01;
      end
      Q2: begin
        mem_rd = 1'b1;
        done   = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
